// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: round-robin arbiter giving requesters 0/1 (req/wr/rs/wd in, ack/rd out) 3-cycle access to memoria_dados (mem_rs/mem_wd/mem_wr out, mem_rd in), ocupado while busy
module arbitro_memoria_dados #(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               wr0,
  input  logic [LARGURA-1:0] rs0,
  input  logic [LARGURA-1:0] wd0,
  output logic               ack0,
  output logic [LARGURA-1:0] rd0,
  input  logic               req1,
  input  logic               wr1,
  input  logic [LARGURA-1:0] rs1,
  input  logic [LARGURA-1:0] wd1,
  output logic               ack1,
  output logic [LARGURA-1:0] rd1,
  output logic [LARGURA-1:0] mem_rs,
  output logic [LARGURA-1:0] mem_wd,
  output logic               mem_wr,
  input  logic [LARGURA-1:0] mem_rd,
  output logic               ocupado
);
  typedef enum logic [1:0] {OCIOSO, ACESSO, RESPOSTA} estado_t;
  estado_t estado_q, estado_d;
  logic wr_q, wr_d, id_q, id_d, ultimo_q, ultimo_d, vence;
  logic [LARGURA-1:0] rs_q, rs_d, wd_q, wd_d, rd0_q, rd0_d, rd1_q, rd1_d;
  assign vence = (req0 && req1) ? ~ultimo_q : req1;
  always_comb begin
    estado_d = estado_q;
    wr_d = wr_q;
    id_d = id_q;
    ultimo_d = ultimo_q;
    rs_d = rs_q;
    wd_d = wd_q;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    case (estado_q)
      OCIOSO: if (req0 || req1) begin
        estado_d = ACESSO;
        id_d = vence;
        ultimo_d = vence;
        wr_d = vence ? wr1 : wr0;
        rs_d = vence ? rs1 : rs0;
        wd_d = vence ? wd1 : wd0;
      end
      ACESSO: begin
        estado_d = RESPOSTA;
        rd0_d = id_q ? rd0_q : mem_rd;
        rd1_d = id_q ? mem_rd : rd1_q;
      end
      default: estado_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      wr_q <= 1'b0;
      id_q <= 1'b0;
      ultimo_q <= 1'b1;
      rs_q <= '0;
      wd_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      estado_q <= estado_d;
      wr_q <= wr_d;
      id_q <= id_d;
      ultimo_q <= ultimo_d;
      rs_q <= rs_d;
      wd_q <= wd_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end
  assign mem_rs = rs_q;
  assign mem_wd = wd_q;
  assign mem_wr = (estado_q == ACESSO) && wr_q && !rst;
  assign ack0 = (estado_q == RESPOSTA) && !id_q;
  assign ack1 = (estado_q == RESPOSTA) && id_q;
  assign rd0 = rd0_q;
  assign rd1 = rd1_q;
  assign ocupado = estado_q != OCIOSO;
endmodule

// File: doc/arbitro_memoria_dados.md
ARBITRO_MEMORIA_DADOS -- requirements
Module: arbitro_memoria_dados

Interface
REQ-001 Parameter: LARGURA, 32, width of address, write data and read data on all ports.
REQ-002 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0  input  1  requester 0 access request, level, held until ack0.
REQ-006 wr0  input  1  requester 0 operation: 1 = write, 0 = read; valid while req0=1.
REQ-007 rs0  input  LARGURA  requester 0 word address; valid while req0=1.
REQ-008 wd0  input  LARGURA  requester 0 write data; valid while req0=1.
REQ-009 ack0  output  1  one-cycle completion pulse to requester 0.
REQ-010 rd0  output  LARGURA  read data to requester 0; valid when ack0=1.
REQ-011 req1, wr1, rs1, wd1, ack1, rd1: identical to REQ-005..REQ-010 for requester 1.
REQ-012 mem_rs  output  LARGURA  address to memoria_dados.
REQ-013 mem_wd  output  LARGURA  write data to memoria_dados.
REQ-014 mem_wr  output  1  write enable to memoria_dados.
REQ-015 mem_rd  input  LARGURA  combinational read data from memoria_dados.
REQ-016 ocupado  output  1  1 whenever state is not OCIOSO.

Function
REQ-017 FSM states: OCIOSO, ACESSO, RESPOSTA; every transition happens on a rising clk edge.
REQ-018 OCIOSO: if neither req0 nor req1 is high, stay; otherwise select a winner, latch its wr/rs/wd into internal registers, record winner id, go to ACESSO.
REQ-019 Arbitration: one requester -> it wins; both -> the requester not recorded in pointer ultimo wins (round-robin); ultimo updates to the winner on entry to ACESSO.
REQ-020 ACESSO lasts exactly one cycle: mem_rs and mem_wd drive the latched address/data; mem_wr = latched wr AND NOT rst; next state RESPOSTA.
REQ-021 On the ACESSO->RESPOSTA edge, mem_rd is captured into the winner's rd register; for a write access the captured value is whatever mem_rd shows and is don't-care to the requester.
REQ-022 RESPOSTA lasts exactly one cycle: ack of the winner = 1, the other ack = 0, mem_wr = 0; next state OCIOSO unconditionally.
REQ-023 Latency: request sampled at edge E0 -> mem_wr (if write) high during cycle E0..E1 -> ack high during cycle E1..E2; throughput one access per 3 cycles minimum.
REQ-024 req0/req1 are ignored in ACESSO and RESPOSTA; a requester still holding req at the RESPOSTA->OCIOSO edge is not re-granted on that edge (first sampling is in OCIOSO).
REQ-025 Outside ACESSO, mem_wr = 0; mem_rs/mem_wd hold the last latched values.
REQ-026 rd0/rd1 hold their last captured value until the next access by the same requester.
REQ-027 ack0 and ack1 are never high in the same cycle; at most one ack pulse per grant.
REQ-028 Changes of rs/wd/wr of the winner after the OCIOSO edge do not affect the access in progress.

Reset
REQ-029 rst sampled high at any edge -> state OCIOSO, ultimo = 1 (requester 0 wins the first contended grant), ack0 = ack1 = 0, mem_rs = mem_wd = rd0 = rd1 = 0, ocupado = 0.
REQ-030 rst asserted during ACESSO -> mem_wr forced 0 in that cycle (no memory write), no ack issued for the aborted access.
REQ-031 rst asserted during RESPOSTA -> ack still visible that cycle (registered), cleared after the edge.

Verification
REQ-032 Req0 write rs0=0, wd0=FEEDF00D, then read rs0=0 -> mem_wr high exactly one cycle, ack0 2 cycles after sampling, read returns rd0=FEEDF00D.
REQ-033 req0 and req1 raised same cycle after reset (req0 write rs=0 wd=FEEDF00D, req1 write rs=1 wd=BEEFCAFE) -> requester 0 served first, requester 1 next; reads of 0 and 1 return FEEDF00D, BEEFCAFE.
REQ-034 Both requesters held continuously for 6 grants -> grants alternate 0,1,0,1,0,1; ack0/ack1 never overlap.
REQ-035 rst pulsed in the ACESSO cycle of req1 write rs1=2 wd=12345678 -> no mem_wr pulse, no ack1, later read of address 2 returns prior contents.
REQ-036 Winner changes rs0 from 0 to 1 in the ACESSO cycle -> mem_rs stays 0 for that access.
